// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding, widths and pointer helper for uart_tx_arbiter
package uart_arb_pkg;

  localparam int STATE_W    = 2;
  localparam int HOLD_CNT_W = 24;

  typedef enum logic [STATE_W-1:0] {
    ARB_IDLE       = 2'd0,
    ARB_WAIT_START = 2'd1,
    ARB_WAIT_DONE  = 2'd2,
    ARB_HOLD       = 2'd3
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte handshake plus uart transmit pins seen by the arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_is_transmitting;

  modport master (
    output req_valid, req_data, req_last, uart_is_transmitting,
    input  req_ack, uart_transmit, uart_tx_byte
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_is_transmitting,
    output req_ack, uart_transmit, uart_tx_byte
  );

endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    // Scan from the farthest offset down so the nearest request is written last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources
// Packet locking, ARB_HOLD and the hold timer exist only when UART_ARB_LOCK_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int HOLD_TIMEOUT = 1000000,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_id,
  output logic              hold_timeout
);

  arb_state_t         state, state_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [IDX_W-1:0]   grant_next, issue_idx, pick_idx;
  logic [NUM_REQ-1:0] ack_next;
  logic [7:0]         tx_byte_next;
  logic               transmit_next, tout_next;
  logic               issue, pick_found;
  logic               lock, lock_next;

`ifdef UART_ARB_LOCK_EN
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_next;
`else
  localparam int unused_hold_timeout = HOLD_TIMEOUT;
  logic unused_last;
  assign unused_last = ^bus.req_last;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    lock_next     = lock;
    grant_next    = grant_id;
    ack_next      = '0;
    transmit_next = 1'b0;
    tx_byte_next  = bus.uart_tx_byte;
    tout_next     = 1'b0;
    issue         = 1'b0;
    issue_idx     = grant_id;
`ifdef UART_ARB_LOCK_EN
    hold_cnt_next = hold_cnt;
`endif

    case (state)
      ARB_IDLE: begin
        // Foreign uart activity blocks any new issue.
        if (pick_found && !bus.uart_is_transmitting) begin
          issue     = 1'b1;
          issue_idx = pick_idx;
        end
      end
      ARB_WAIT_START: begin
        if (bus.uart_is_transmitting) begin
          state_next = ARB_WAIT_DONE;
        end
      end
      ARB_WAIT_DONE: begin
        if (!bus.uart_is_transmitting) begin
          if (lock) begin
            state_next = ARB_HOLD;
`ifdef UART_ARB_LOCK_EN
            hold_cnt_next = '0;
`endif
          end else begin
            state_next = ARB_IDLE;
            ptr_next   = IDX_W'(rr_next(int'(grant_id), NUM_REQ));
          end
        end
      end
`ifdef UART_ARB_LOCK_EN
      ARB_HOLD: begin
        // A byte arriving on the timeout cycle still wins over the timeout.
        if (bus.req_valid[grant_id]) begin
          issue     = 1'b1;
          issue_idx = grant_id;
        end else if (hold_cnt >= HOLD_CNT_W'(HOLD_TIMEOUT - 1)) begin
          tout_next  = 1'b1;
          lock_next  = 1'b0;
          ptr_next   = IDX_W'(rr_next(int'(grant_id), NUM_REQ));
          state_next = ARB_IDLE;
        end else if (hold_cnt != '1) begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
`endif
      default: begin
        state_next = ARB_IDLE;
      end
    endcase

    if (issue) begin
      transmit_next       = 1'b1;
      ack_next[issue_idx] = 1'b1;
      tx_byte_next        = bus.req_data[8*issue_idx +: 8];
      grant_next          = issue_idx;
      state_next          = ARB_WAIT_START;
`ifdef UART_ARB_LOCK_EN
      lock_next           = ~bus.req_last[issue_idx];
`else
      lock_next           = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ARB_IDLE;
      ptr               <= '0;
      lock              <= 1'b0;
      grant_id          <= '0;
      busy              <= 1'b0;
      hold_timeout      <= 1'b0;
      bus.req_ack       <= '0;
      bus.uart_transmit <= 1'b0;
      bus.uart_tx_byte  <= '0;
    end else begin
      state             <= state_next;
      ptr               <= ptr_next;
      lock              <= lock_next;
      grant_id          <= grant_next;
      busy              <= (state_next != ARB_IDLE);
      hold_timeout      <= tout_next;
      bus.req_ack       <= ack_next;
      bus.uart_transmit <= transmit_next;
      bus.uart_tx_byte  <= tx_byte_next;
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a behavioural uart and grant-order model
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int HOLD_TIMEOUT = 16;
  localparam int UART_CYCLES  = 10 * 4;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] grant_id;
  logic       hold_timeout;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .grant_id     (grant_id),
    .hold_timeout (hold_timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [8:0]  drv_mem [NUM_REQ][16];
  int          drv_wr  [NUM_REQ];
  int          drv_rd  [NUM_REQ];
  logic [10:0] exp_q[$];
  logic [10:0] exp_all[$];
  logic [7:0]  obs_q[$];
  int          obs_id[$];
  int          exp_tout;
  int          n_tout, n_ack;
  int          cyc = 0;
  int          fall_cyc, hold_gap, pulse_cyc, last_issue_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit drained();
    bit d;
    d = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (drv_rd[i] != drv_wr[i]) d = 1'b0;
    return d;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_wr[i] = 0;
      drv_rd[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    drv_mem[i][drv_wr[i]] = {l, d};
    drv_wr[i]++;
  endtask

  // Message-level model: round-robin over whole queues; a locked owner with nothing left times out.
  task automatic model_run();
    int  ptr, g, c;
    bit  lk, any;
    int  rd [NUM_REQ];
    ptr = 0; g = 0; lk = 1'b0;
    exp_tout = 0;
    exp_all.delete();
    for (int i = 0; i < NUM_REQ; i++) rd[i] = 0;
    for (int step = 0; step < 64; step++) begin
      if (lk && rd[g] >= drv_wr[g]) begin
        lk = 1'b0;
        ptr = (g + 1) % NUM_REQ;
        exp_tout++;
      end
      if (!lk) begin
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (ptr + k) % NUM_REQ;
          if (!any && rd[c] < drv_wr[c]) begin
            any = 1'b1;
            g = c;
          end
        end
        if (!any) break;
      end
      exp_all.push_back({3'(g), drv_mem[g][rd[g]][7:0]});
      lk = LOCK_EN && !drv_mem[g][rd[g]][8];
      rd[g]++;
      if (!lk) ptr = (g + 1) % NUM_REQ;
    end
    exp_q = exp_all;
  endtask

  task automatic begin_phase();
    model_run();
    obs_q.delete();
    obs_id.delete();
    n_tout = 0;
    n_ack = 0;
    hold_gap = -1;
    pulse_cyc = 0;
    last_issue_cyc = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_first_issue(input string name, input int idx, input logic [7:0] b);
    @(negedge clk);
    check({name, "_pre_ack"}, bus.req_ack, 0);
    check({name, "_pre_transmit"}, bus.uart_transmit, 0);
    @(negedge clk);
    check({name, "_ack"}, bus.req_ack, 32'd1 << idx);
    check({name, "_transmit"}, bus.uart_transmit, 1);
    check({name, "_tx_byte"}, bus.uart_tx_byte, b);
    check({name, "_grant_id"}, grant_id, idx);
    check({name, "_busy"}, busy, 1);
    @(negedge clk);
    check({name, "_ack_drop"}, bus.req_ack, 0);
    check({name, "_transmit_drop"}, bus.uart_transmit, 0);
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      done = drained() && !busy && !bus.uart_is_transmitting && (exp_q.size() == 0);
    end
    check({name, "_completes"}, done, 1);
    check({name, "_count"}, obs_q.size(), exp_all.size());
    for (int k = 0; k < exp_all.size() && k < obs_q.size(); k++) begin
      check({name, "_serial_byte"}, obs_q[k], exp_all[k][7:0]);
    end
    check({name, "_timeouts"}, n_tout, exp_tout);
  endtask

  // Requesters: hold the head byte until acked, then present the next one.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ack[i] && drv_rd[i] < drv_wr[i]) drv_rd[i]++;
        if (drv_rd[i] < drv_wr[i]) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = drv_mem[i][drv_rd[i]][7:0];
          bus.req_last[i]       = drv_mem[i][drv_rd[i]][8];
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]       = 1'b0;
        end
      end
    end
  end

  // Behavioural uart: one pulse on transmit starts a 10-bit frame at divide 4.
  initial begin
    logic       seen, r;
    logic [7:0] b;
    int         cnt;
    bus.uart_is_transmitting = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      seen = bus.uart_transmit;
      b    = bus.uart_tx_byte;
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        bus.uart_is_transmitting = 1'b0;
        cnt = 0;
      end else if (!bus.uart_is_transmitting) begin
        if (seen) begin
          bus.uart_is_transmitting = 1'b1;
          cnt = UART_CYCLES - 1;
          obs_q.push_back(b);
        end
      end else if (cnt == 0) begin
        bus.uart_is_transmitting = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  // Per-cycle compare against the model's expected issue sequence.
  initial begin
    logic [3:0]  prev_ack;
    logic        prev_to, prev_tx;
    logic [10:0] e;
    prev_ack = '0;
    prev_to  = 1'b0;
    prev_tx  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ack_onehot0", $onehot0(bus.req_ack), 1);
        if (bus.req_ack != '0) begin
          n_ack++;
          last_issue_cyc = cyc;
          obs_id.push_back(int'(grant_id));
          check("ack_matches_grant", bus.req_ack, 32'd1 << grant_id);
          check("transmit_with_ack", bus.uart_transmit, 1);
          check("ack_single_cycle", prev_ack, 0);
          check("issue_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("issue_grant_id", grant_id, e[10:8]);
            check("issue_tx_byte", bus.uart_tx_byte, e[7:0]);
          end
        end else begin
          check("transmit_without_ack", bus.uart_transmit, 0);
        end
        if (prev_tx && !bus.uart_is_transmitting) fall_cyc = cyc;
        if (hold_timeout) begin
          n_tout++;
          pulse_cyc = cyc;
          hold_gap = cyc - fall_cyc;
          check("timeout_single_cycle", prev_to, 0);
        end
`ifndef UART_ARB_LOCK_EN
        check("timeout_tied_low", hold_timeout, 0);
`endif
      end
      prev_ack = bus.req_ack;
      prev_to  = hold_timeout;
      prev_tx  = bus.uart_is_transmitting;
    end
  end

  initial begin
    int lit_lock [5];
    rst = 1'b1;
    clear_all();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_ack", bus.req_ack, 0);
    check("reset_transmit", bus.uart_transmit, 0);
    check("reset_tx_byte", bus.uart_tx_byte, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_hold_timeout", hold_timeout, 0);
    rst = 1'b0;

    // Single request on requester 2.
    apply_reset();
    load(2, 8'h41, 1'b1);
    begin_phase();
    expect_first_issue("single", 2, 8'h41);
    wait_done("single");
    check("single_busy_after", busy, 0);

    // All four contend, two single-byte messages each.
    apply_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < NUM_REQ; i++) load(i, 8'h30 + 8'(i), 1'b1);
    begin_phase();
    wait_done("contention");
    check("contention_acks", n_ack, 8);
    for (int k = 0; k < 8 && k < obs_q.size(); k++) check("contention_order", obs_q[k], 8'h30 + 8'(k % 4));

    // Three-byte message on req0 while req1 has two single-byte messages.
    apply_reset();
    load(0, 8'hA0, 1'b0);
    load(0, 8'hA1, 1'b0);
    load(0, 8'hA2, 1'b1);
    load(1, 8'hB0, 1'b1);
    load(1, 8'hB1, 1'b1);
    begin_phase();
    wait_done("lock");
`ifdef UART_ARB_LOCK_EN
    lit_lock = '{0, 0, 0, 1, 1};
`else
    lit_lock = '{0, 1, 0, 1, 0};
`endif
    check("lock_grant_count", obs_id.size(), 5);
    for (int k = 0; k < 5 && k < obs_id.size(); k++) check("lock_grant_order", obs_id[k], lit_lock[k]);
    check("lock_no_timeout", n_tout, 0);

    // Unterminated message on req0 with req1 pending.
    apply_reset();
    load(0, 8'hC0, 1'b0);
    load(1, 8'hC1, 1'b1);
    begin_phase();
    wait_done("timeout");
    check("timeout_grant_count", obs_id.size(), 2);
    if (obs_id.size() == 2) begin
      check("timeout_first_grant", obs_id[0], 0);
      check("timeout_second_grant", obs_id[1], 1);
    end
`ifdef UART_ARB_LOCK_EN
    check("timeout_pulses", n_tout, 1);
    check("timeout_hold_gap", hold_gap, 17);
    check("timeout_regrant_gap", last_issue_cyc - pulse_cyc, 1);
`else
    check("timeout_pulses", n_tout, 0);
`endif

    // Reset while the uart is mid-byte.
    apply_reset();
    load(2, 8'h55, 1'b1);
    begin_phase();
    for (int k = 0; k < 100 && !bus.uart_is_transmitting; k++) @(negedge clk);
    check("midreset_uart_started", bus.uart_is_transmitting, 1);
    repeat (3) @(negedge clk);
    check("midreset_pre_busy", busy, 1);
    check("midreset_pre_grant", grant_id, 2);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_transmit", bus.uart_transmit, 0);
    check("midreset_ack", bus.req_ack, 0);
    check("midreset_grant_id", grant_id, 0);
    check("midreset_uart_idle", bus.uart_is_transmitting, 0);
    rst = 1'b0;
    clear_all();
    load(3, 8'h7E, 1'b1);
    begin_phase();
    expect_first_issue("post_reset", 3, 8'h7E);
    wait_done("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
